// File: rtl/calc1_pkg.sv
// Shared constants and types for the calc1 request/response responder.
// Commands, response codes, port FSM states and default widths.
package calc1_pkg;

    localparam int unsigned NUM_PORTS_DEF = 4;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned SHAMT_W_DEF   = 5;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StOp2,
        StWait,
        StResp
    } port_state_e;

endpackage

// File: rtl/calc1_port_responder_if.sv
// Bundle of per-port request/response signals between requesters and the responder.
// Bit 0 of cmd/data is the MSB (big-endian numbering), value semantics are unchanged.
interface calc1_port_responder_if
    import calc1_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF
);

    logic [0:3]        req_cmd_in  [1:NUM_PORTS];
    logic [0:DATA_W-1] req_data_in [1:NUM_PORTS];
    logic [1:0]        out_resp    [1:NUM_PORTS];
    logic [0:DATA_W-1] out_data    [1:NUM_PORTS];
    logic              in_rdy      [1:NUM_PORTS];

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  in_rdy
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output in_rdy
    );

endinterface

// File: rtl/calc1_alu.sv
// Combinational calc1 ALU: unsigned add/sub with overflow error, logical shifts.
// Any unsupported command yields an error response with zero data.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic [0:3]        i_cmd,
    input  logic [0:DATA_W-1] i_op1,
    input  logic [0:DATA_W-1] i_op2,
    output logic [1:0]        o_resp,
    output logic [0:DATA_W-1] o_data
);

    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_diff;
    logic [SHAMT_W-1:0] w_shamt;

    // The extra top bit holds carry (add) or borrow (sub).
    assign w_sum   = {1'b0, i_op1} + {1'b0, i_op2};
    assign w_diff  = {1'b0, i_op1} - {1'b0, i_op2};
    assign w_shamt = i_op2[DATA_W-SHAMT_W:DATA_W-1];

    always_comb begin
        o_resp = RESP_ERR;
        o_data = '0;
        case (i_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    o_resp = RESP_OK;
                    o_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (!w_diff[DATA_W]) begin
                    o_resp = RESP_OK;
                    o_data = w_diff[DATA_W-1:0];
                end
            end
            CMD_LSH: begin
                o_resp = RESP_OK;
                o_data = i_op1 << w_shamt;
            end
            CMD_RSH: begin
                o_resp = RESP_OK;
                o_data = i_op1 >> w_shamt;
            end
            default: begin
                o_resp = RESP_ERR;
                o_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Multi-port calc1 responder: per-port command/operand capture FSMs sharing one ALU
// through a round-robin arbiter; each result is held on its port for one cycle.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned SHAMT_W   = SHAMT_W_DEF
) (
    input  logic                   c_clk,
    input  logic                   reset,
    calc1_port_responder_if.slave  bus
);

    port_state_e       r_state     [1:NUM_PORTS];
    port_state_e       w_state_nxt [1:NUM_PORTS];
    logic [0:3]        r_cmd       [1:NUM_PORTS];
    logic [0:DATA_W-1] r_op1       [1:NUM_PORTS];
    logic [0:DATA_W-1] r_op2       [1:NUM_PORTS];
    logic [1:0]        r_resp      [1:NUM_PORTS];
    logic [0:DATA_W-1] r_data      [1:NUM_PORTS];
    logic              w_req       [1:NUM_PORTS];
    logic              w_gnt       [1:NUM_PORTS];

    logic [2:0]        r_last;
    logic              w_gnt_vld;
    logic [2:0]        w_gnt_idx;
    int                w_cand;

    logic [0:3]        w_alu_cmd;
    logic [0:DATA_W-1] w_alu_op1;
    logic [0:DATA_W-1] w_alu_op2;
    logic [1:0]        w_alu_resp;
    logic [0:DATA_W-1] w_alu_data;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 3'd1;
        w_cand    = 1;
        for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            w_cand = (int'(r_last) + k - 1) % int'(NUM_PORTS) + 1;
            if (!w_gnt_vld && w_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = 3'(w_cand);
            end
        end
    end

    always_comb begin
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            w_req[i] = (r_state[i] == StWait);
            w_gnt[i] = w_gnt_vld && (w_gnt_idx == 3'(i));
        end
    end

    always_comb begin
        w_alu_cmd = r_cmd[w_gnt_idx];
        w_alu_op1 = r_op1[w_gnt_idx];
        w_alu_op2 = r_op2[w_gnt_idx];
    end

    calc1_alu #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .i_cmd  (w_alu_cmd),
        .i_op1  (w_alu_op1),
        .i_op2  (w_alu_op2),
        .o_resp (w_alu_resp),
        .o_data (w_alu_data)
    );

    // FSM state register and arbiter pointer.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 1; i <= int'(NUM_PORTS); i++) begin
                r_state[i] <= StIdle;
            end
            r_last <= 3'(NUM_PORTS);
        end else begin
            for (int i = 1; i <= int'(NUM_PORTS); i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            if (w_gnt_vld) begin
                r_last <= w_gnt_idx;
            end
        end
    end

    always_comb begin
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                StIdle: if (bus.req_cmd_in[i] != CMD_NOP) w_state_nxt[i] = StOp2;
                StOp2:  w_state_nxt[i] = StWait;
                StWait: if (w_gnt[i]) w_state_nxt[i] = StResp;
                StResp: w_state_nxt[i] = StIdle;
                default: w_state_nxt[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 1; i <= int'(NUM_PORTS); i++) begin
                r_cmd[i]  <= '0;
                r_op1[i]  <= '0;
                r_op2[i]  <= '0;
                r_resp[i] <= RESP_NONE;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= int'(NUM_PORTS); i++) begin
                if (r_state[i] == StIdle && bus.req_cmd_in[i] != CMD_NOP) begin
                    r_cmd[i] <= bus.req_cmd_in[i];
                    r_op1[i] <= bus.req_data_in[i];
                end
                if (r_state[i] == StOp2) begin
                    r_op2[i] <= bus.req_data_in[i];
                end
                if (w_gnt[i]) begin
                    r_resp[i] <= w_alu_resp;
                    r_data[i] <= w_alu_data;
                end else if (r_state[i] == StResp) begin
                    r_resp[i] <= RESP_NONE;
                    r_data[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 1; i <= int'(NUM_PORTS); i++) begin
            bus.in_rdy[i]   = (r_state[i] == StIdle);
            bus.out_resp[i] = r_resp[i];
            bus.out_data[i] = r_data[i];
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder: vector table of single-port commands
// plus hand-written contention, reset-abort and busy-command sequences.
module tb_calc1_port_responder;
    import calc1_pkg::*;

    localparam int NP = 4;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 c_clk = ~c_clk;

    calc1_port_responder_if #(.NUM_PORTS(NP), .DATA_W(32)) bus ();

    calc1_port_responder #(
        .NUM_PORTS (NP),
        .DATA_W    (32),
        .SHAMT_W   (5)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input int p);
        int budget = 20;
        while (bus.in_rdy[p] !== 1'b1 && budget > 0) begin
            @(negedge c_clk);
            budget--;
        end
        if (budget == 0) check("rdy_timeout", 32'(bus.in_rdy[p]), 32'd1);
    endtask

    // Command at edge E, op2 at E+1, response between E+2 and E+3.
    task automatic run_vec(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [1:0] resp,
                           input logic [31:0] data);
        @(negedge c_clk);
        wait_rdy(p);
        bus.req_cmd_in[p]  = cmd;
        bus.req_data_in[p] = op1;
        @(negedge c_clk);
        bus.req_cmd_in[p]  = 4'hF;  // ignored while the port collects op2
        bus.req_data_in[p] = op2;
        @(negedge c_clk);
        bus.req_cmd_in[p]  = 4'h0;
        bus.req_data_in[p] = 32'h0;
        check("busy_rdy", 32'(bus.in_rdy[p]), 32'd0);
        check("early_resp", 32'(bus.out_resp[p]), 32'd0);
        @(negedge c_clk);
        check("resp", 32'(bus.out_resp[p]), 32'(resp));
        check("data", bus.out_data[p], data);
        @(negedge c_clk);
        check("resp_clr", 32'(bus.out_resp[p]), 32'd0);
        check("data_clr", bus.out_data[p], 32'd0);
        check("rdy_back", 32'(bus.in_rdy[p]), 32'd1);
    endtask

    // All ports issue at one edge; grants must go 1,2,3,4 in consecutive cycles.
    task automatic contention_round();
        @(negedge c_clk);
        for (int p = 1; p <= NP; p++) begin
            check("cont_rdy", 32'(bus.in_rdy[p]), 32'd1);
            bus.req_cmd_in[p]  = CMD_ADD;
            bus.req_data_in[p] = 32'h5555_5555;
        end
        @(negedge c_clk);
        for (int p = 1; p <= NP; p++) begin
            bus.req_cmd_in[p]  = 4'h0;
            bus.req_data_in[p] = 32'h5555_5555;
        end
        @(negedge c_clk);
        for (int p = 1; p <= NP; p++) bus.req_data_in[p] = 32'h0;
        for (int k = 1; k <= NP; k++) begin
            @(negedge c_clk);
            for (int p = 1; p <= NP; p++) begin
                check("cont_resp", 32'(bus.out_resp[p]), (p == k) ? 32'd1 : 32'd0);
                check("cont_data", bus.out_data[p], (p == k) ? 32'hAAAA_AAAA : 32'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, CMD_ADD, 32'hFFFF_0000, 32'h0000_FFFF, RESP_OK,  32'hFFFF_FFFF};
        vecs[1]  = '{2, CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, RESP_ERR, 32'h0};
        vecs[2]  = '{2, CMD_SUB, 32'h8000_0000, 32'h0000_0001, RESP_OK,  32'h7FFF_FFFF};
        vecs[3]  = '{2, CMD_SUB, 32'h0000_0000, 32'h0000_0001, RESP_ERR, 32'h0};
        vecs[4]  = '{2, CMD_SUB, 32'h1234_5678, 32'h1234_5678, RESP_OK,  32'h0};
        vecs[5]  = '{3, CMD_LSH, 32'h0000_0001, 32'h0000_001F, RESP_OK,  32'h8000_0000};
        vecs[6]  = '{3, CMD_RSH, 32'h8000_0000, 32'h0000_0021, RESP_OK,  32'h4000_0000};
        vecs[7]  = '{4, 4'd3,    32'h0000_0005, 32'h0000_0005, RESP_ERR, 32'h0};
        vecs[8]  = '{4, CMD_LSH, 32'hF000_0001, 32'hFFFF_FFE4, RESP_OK,  32'h0000_0010};
        vecs[9]  = '{1, CMD_RSH, 32'hFFFF_FFFF, 32'h0000_0000, RESP_OK,  32'hFFFF_FFFF};
        vecs[10] = '{3, CMD_ADD, 32'h7FFF_FFFF, 32'h0000_0001, RESP_OK,  32'h8000_0000};
        vecs[11] = '{4, 4'hF,    32'h1111_1111, 32'h2222_2222, RESP_ERR, 32'h0};

        for (int p = 1; p <= NP; p++) begin
            bus.req_cmd_in[p]  = 4'h0;
            bus.req_data_in[p] = 32'h0;
        end

        reset = 1'b1;
        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 1; p <= NP; p++) begin
            check("rst_rdy", 32'(bus.in_rdy[p]), 32'd1);
            check("rst_resp", 32'(bus.out_resp[p]), 32'd0);
            check("rst_data", bus.out_data[p], 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i].port, vecs[i].cmd, vecs[i].op1, vecs[i].op2,
                    vecs[i].resp, vecs[i].data);
        end

        contention_round();
        contention_round();

        // Reset while port 1 waits for the ALU: the pending result must vanish.
        @(negedge c_clk);
        bus.req_cmd_in[1]  = CMD_SUB;
        bus.req_data_in[1] = 32'd5;
        @(negedge c_clk);
        bus.req_cmd_in[1]  = 4'h0;
        bus.req_data_in[1] = 32'd3;
        @(negedge c_clk);
        bus.req_data_in[1] = 32'd0;
        check("abort_busy", 32'(bus.in_rdy[1]), 32'd0);
        reset = 1'b1;
        @(negedge c_clk);
        check("abort_rdy", 32'(bus.in_rdy[1]), 32'd1);
        check("abort_resp", 32'(bus.out_resp[1]), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge c_clk);
            check("abort_quiet", 32'(bus.out_resp[1]), 32'd0);
        end
        run_vec(1, CMD_ADD, 32'h0, 32'h0, RESP_OK, 32'h0);

        // Commands held while busy must not spawn extra responses.
        @(negedge c_clk);
        bus.req_cmd_in[2]  = CMD_ADD;
        bus.req_data_in[2] = 32'd1;
        @(negedge c_clk);
        bus.req_data_in[2] = 32'd2;
        @(negedge c_clk);
        bus.req_data_in[2] = 32'd7;
        @(negedge c_clk);
        check("busy_cmd_resp", 32'(bus.out_resp[2]), 32'd1);
        check("busy_cmd_data", bus.out_data[2], 32'd3);
        bus.req_cmd_in[2]  = 4'h0;
        bus.req_data_in[2] = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge c_clk);
            check("no_extra_resp", 32'(bus.out_resp[2]), 32'd0);
            check("no_extra_rdy", 32'(bus.in_rdy[2]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
